uart_out_unit: RTL



---
 rtl/uart_out_unit_if.sv | 10 +
 rtl/uart_out_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_out_unit_if.sv
// Core-to-UART output handshake: the core offers a byte with out_req/out_data,
// the UART pushes back with out_busy while its FIFO is full.
interface uart_out_unit_if;
    logic        out_req;
    logic [31:0] out_data;
    logic        out_busy;

    modport master (output out_req, output out_data, input out_busy);
    modport slave  (input out_req, input out_data, output out_busy);
endinterface

// File: rtl/uart_out_unit.sv
// Byte FIFO plus UART transmitter (8N1, LSB first) at the far end of the core's OUT path.
// Define UART_OUT_PARITY_EN to insert an even-parity bit and send 8E1 frames instead.
module uart_out_unit #(
    parameter int CLK_PER_BIT     = 868,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic           clk,
    input  logic           rstn,
    uart_out_unit_if.slave core,
    output logic           txd,
    output logic           tx_idle
);
    localparam int AW = FIFO_DEPTH_LOG2;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
    localparam logic [15:0] BIT_LAST   = 16'(CLK_PER_BIT - 1);

`ifdef UART_OUT_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [1 << AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_OUT_PARITY_EN
    logic          parity_bit;
`endif
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          unused_data_hi;

    // Only the low byte is transmitted; the upper word bits are don't-care.
    assign unused_data_hi = ^core.out_data[31:8];

    assign core.out_busy = (count == FULL_COUNT);
    assign push          = core.out_req && !core.out_busy;
    assign bit_end       = (baud_cnt == BIT_LAST);
    // The FSM pops only when it is about to start a frame, and never from an empty FIFO.
    assign pop           = (count != '0) && ((state == IDLE) || (state == STOP && bit_end));

    // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= core.out_data[7:0];
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            txd        <= 1'b1;
            tx_idle    <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
`ifdef UART_OUT_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_idle  <= 1'b0;
            baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
`ifdef UART_OUT_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        txd        <= 1'b0;
                        state      <= START;
                    end else begin
                        tx_idle <= !push;
                    end
                end
                START: begin
                    if (bit_end) begin
                        txd     <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
                            txd   <= parity_bit;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef UART_OUT_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            // Next byte starts immediately: no idle gap between frames.
                            shift      <= mem[rd_ptr];
`ifdef UART_OUT_PARITY_EN
                            parity_bit <= ^mem[rd_ptr];
`endif
                            txd        <= 1'b0;
                            state      <= START;
                        end else begin
                            txd     <= 1'b1;
                            state   <= IDLE;
                            tx_idle <= !push;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
